// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: bus widths, response codes and the channel
// FSM state encodings used by the register-file responder.
package axil_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB       = $clog2(AXI_STRB_WIDTH);

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

endpackage

// File: rtl/axil_regfile_addr_dec.sv
// Combinational byte-address decoder for the register file. Produces the
// register index and hit flag, plus the status-word index and hit flag for
// the window directly above the RW registers.
import axil_pkg::*;

module axil_regfile_addr_dec #(
    parameter int                          NUM_REGS   = 16,
    parameter int                          NUM_STATUS = 4,
    parameter logic [AXI_ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
    parameter int                          REG_IDX_W  = 4,
    parameter int                          STAT_IDX_W = 2
) (
    input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
    output logic [REG_IDX_W-1:0]      o_reg_idx,
    output logic                      o_hit,
    output logic [STAT_IDX_W-1:0]     o_stat_idx,
    output logic                      o_status_hit
);

    logic [AXI_ADDR_WIDTH-1:0] w_off;
    logic [AXI_ADDR_WIDTH-1:0] w_word;

    // Offset wraps at the address width, so addresses below BASE_ADDR land far
    // above the register window and decode as misses.
    assign w_off  = i_addr - BASE_ADDR;
    assign w_word = w_off >> ADDR_LSB;

    assign o_hit        = (w_word < AXI_ADDR_WIDTH'(NUM_REGS));
    assign o_status_hit = !o_hit && (w_word < AXI_ADDR_WIDTH'(NUM_REGS + NUM_STATUS));
    assign o_reg_idx    = REG_IDX_W'(w_word);
    assign o_stat_idx   = STAT_IDX_W'(w_word - AXI_ADDR_WIDTH'(NUM_REGS));

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI-Lite responder with NUM_REGS read/write registers exported to fabric,
// plus a one-cycle write pulse per committed register write.
// Optional: define AXIL_REGFILE_STATUS_EN to add read-only status words
// (input status_in) decoded directly above the RW registers.
import axil_pkg::*;

module axil_slave_regfile #(
    parameter int                          NUM_REGS   = 16,
    parameter logic [AXI_ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
    parameter logic [AXI_DATA_WIDTH-1:0]   RESET_VAL  = '0,
    parameter int                          NUM_STATUS = 4
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [AXI_STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    output logic [1:0]                s_axil_bresp,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]                s_axil_rresp,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready,
`ifdef AXIL_REGFILE_STATUS_EN
    input  logic [AXI_DATA_WIDTH-1:0] status_in [NUM_STATUS],
`endif
    output logic [AXI_DATA_WIDTH-1:0] reg_q [NUM_REGS],
    output logic [NUM_REGS-1:0]       wr_pulse
);

    localparam int REG_IDX_W  = $clog2(NUM_REGS);
    localparam int STAT_IDX_W = (NUM_STATUS > 1) ? $clog2(NUM_STATUS) : 1;

    // Write channel state
    wstate_t                   r_wstate;
    logic                      r_aw_held, r_w_held;
    logic                      r_awready, r_wready;
    logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [AXI_STRB_WIDTH-1:0] r_wstrb;
    logic                      r_bvalid;
    logic [1:0]                r_bresp;
    logic [NUM_REGS-1:0]       r_wr_pulse;
    logic [AXI_DATA_WIDTH-1:0] r_regs [NUM_REGS];

    // Read channel state
    rstate_t                   r_rstate;
    logic                      r_arready;
    logic                      r_rvalid;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                r_rresp;

    // Decoder outputs
    logic [REG_IDX_W-1:0]      w_wr_idx, w_rd_idx;
    logic [STAT_IDX_W-1:0]     w_wr_stat_idx, w_rd_stat_idx;
    logic                      w_wr_hit, w_rd_hit;
    logic                      w_wr_status_hit, w_rd_status_hit;
    logic [AXI_DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]                w_rd_resp;
    logic                      w_aw_hs, w_w_hs, w_ar_hs;

    axil_regfile_addr_dec #(
        .NUM_REGS   (NUM_REGS),
        .NUM_STATUS (NUM_STATUS),
        .BASE_ADDR  (BASE_ADDR),
        .REG_IDX_W  (REG_IDX_W),
        .STAT_IDX_W (STAT_IDX_W)
    ) u_wr_dec (
        .i_addr       (r_awaddr),
        .o_reg_idx    (w_wr_idx),
        .o_hit        (w_wr_hit),
        .o_stat_idx   (w_wr_stat_idx),
        .o_status_hit (w_wr_status_hit)
    );

    axil_regfile_addr_dec #(
        .NUM_REGS   (NUM_REGS),
        .NUM_STATUS (NUM_STATUS),
        .BASE_ADDR  (BASE_ADDR),
        .REG_IDX_W  (REG_IDX_W),
        .STAT_IDX_W (STAT_IDX_W)
    ) u_rd_dec (
        .i_addr       (s_axil_araddr),
        .o_reg_idx    (w_rd_idx),
        .o_hit        (w_rd_hit),
        .o_stat_idx   (w_rd_stat_idx),
        .o_status_hit (w_rd_status_hit)
    );

    // Status-window writes are plain SLVERR, so the write-side status decode is
    // never consumed; without the status feature the read side is unused too.
    logic w_unused;
`ifdef AXIL_REGFILE_STATUS_EN
    assign w_unused = &{1'b0, w_wr_stat_idx, w_wr_status_hit};
`else
    assign w_unused = &{1'b0, w_wr_stat_idx, w_wr_status_hit, w_rd_stat_idx, w_rd_status_hit};
`endif

    assign w_aw_hs = s_axil_awvalid && r_awready;
    assign w_w_hs  = s_axil_wvalid  && r_wready;
    assign w_ar_hs = s_axil_arvalid && r_arready;

    // Select read data/response for the address currently on the AR channel
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        w_rd_data = '0;
        w_rd_resp = AXIL_RESP_SLVERR;
        if (w_rd_hit) begin
            w_rd_data = r_regs[w_rd_idx];
            w_rd_resp = AXIL_RESP_OKAY;
        end
`ifdef AXIL_REGFILE_STATUS_EN
        else if (w_rd_status_hit) begin
            w_rd_data = status_in[w_rd_stat_idx];
            w_rd_resp = AXIL_RESP_OKAY;
        end
`endif
    end

    // Write FSM: capture AW and W independently, commit, then hold B until accepted
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wstate   <= W_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= AXIL_RESP_OKAY;
            r_wr_pulse <= '0;
            // NOTE: these are software-visible flops, not a RAM, so resetting the array is intended.
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else begin
            // NOTE: non-blocking throughout; the pulse default below is overridden by a later commit.
            r_wr_pulse <= '0;
            case (r_wstate)
                W_IDLE: begin
                    if (r_aw_held && r_w_held) begin
                        if (w_wr_hit) begin
                            for (int k = 0; k < AXI_STRB_WIDTH; k++) begin
                                if (r_wstrb[k]) begin
                                    r_regs[w_wr_idx][8*k +: 8] <= r_wdata[8*k +: 8];
                                end
                            end
                            r_wr_pulse[w_wr_idx] <= 1'b1;
                            r_bresp              <= AXIL_RESP_OKAY;
                        end else begin
                            r_bresp <= AXIL_RESP_SLVERR;
                        end
                        r_bvalid <= 1'b1;
                        r_wstate <= W_RESP;
                    end else begin
                        if (w_aw_hs) begin
                            r_awaddr  <= s_axil_awaddr;
                            r_aw_held <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_wdata  <= s_axil_wdata;
                            r_wstrb  <= s_axil_wstrb;
                            r_w_held <= 1'b1;
                        end
                        // Ready stays low once a beat is held; also raises it after reset.
                        r_awready <= !(r_aw_held || w_aw_hs);
                        r_wready  <= !(r_w_held  || w_w_hs);
                    end
                end
                W_RESP: begin
                    if (s_axil_bready) begin
                        r_bvalid  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM: register data/response at the AR handshake, hold until accepted
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= AXIL_RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata   <= w_rd_data;
                        r_rresp   <= w_rd_resp;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axil_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axil_awready = r_awready;
    assign s_axil_wready  = r_wready;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_arready = r_arready;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = r_rresp;
    assign reg_q          = r_regs;
    assign wr_pulse       = r_wr_pulse;

endmodule
